// File: rtl/mem_io_if.sv
// Processor-to-memory bus: address, write data, write strobe and read data.
// The processor side drives ADDR/DOUT/W; the responder returns DIN.
interface mem_io_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;

    modport master (output ADDR, output DOUT, output W, input DIN);
    modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: word RAM plus LED, switch, timer and HEX registers.
// Every access returns data on DIN one edge later; writes are read-first.
module mem_io_responder #(
    parameter int RAM_AW   = 7,
    parameter int PRESCALE = 50000,
    parameter int SW_W     = 10,
    parameter int LED_W    = 10
) (
    input  logic             clock,
    input  logic             resetn,
    mem_io_if.slave          bus,
    input  logic [SW_W-1:0]  SW,
    output logic [LED_W-1:0] LEDR,
    output logic [15:0]      HEX_val,
    output logic             bus_err
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [15:0]       mem_q [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic [3:0]        region;
    logic              tick;

    logic [15:0]      din_q, din_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [15:0]      hex_q, hex_d;
    logic [15:0]      timer_q, timer_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [SW_W-1:0]  sw_s1_q, sw_s1_d;
    logic [SW_W-1:0]  sw_sync_q, sw_sync_d;
    logic             err_q, err_d;

    // Address bits between the RAM index and the region nibble alias.
    logic unused_addr;
    assign unused_addr = ^bus.ADDR[11:RAM_AW];

    assign region  = bus.ADDR[15:12];
    assign ram_idx = bus.ADDR[RAM_AW-1:0];
    assign tick    = (presc_q == PMAX);

    assign bus.DIN = din_q;
    assign LEDR    = led_q;
    assign HEX_val = hex_q;
    assign bus_err = err_q;

    // Decode the region, pick read data from pre-edge state, compute updates.
    always_comb begin
        din_d     = '0;
        led_d     = led_q;
        hex_d     = hex_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        sw_s1_d   = SW;
        sw_sync_d = sw_s1_q;
        if (tick) begin
            presc_d = '0;
            timer_d = timer_q + 16'd1;
        end else begin
            presc_d = presc_q + 1'b1;
            timer_d = timer_q;
        end
        case (region)
            4'h0: begin
                din_d  = mem_q[ram_idx];
                ram_we = bus.W;
            end
            4'h1: begin
                din_d = 16'(led_q);
                if (bus.W) begin
                    led_d = bus.DOUT[LED_W-1:0];
                end
            end
            4'h2: begin
                din_d = 16'(sw_sync_q);
            end
            4'h3: begin
                din_d = timer_q;
                if (bus.W) begin
                    timer_d = bus.DOUT;
                    presc_d = '0;
                end
            end
            4'h4: begin
                din_d = hex_q;
                if (bus.W) begin
                    hex_d = bus.DOUT;
                end
            end
            default: begin
                err_d = 1'b1;
            end
        endcase
    end

    // Register file of I/O state, read data and switch synchronizer.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            din_q     <= '0;
            led_q     <= '0;
            hex_q     <= '0;
            timer_q   <= '0;
            presc_q   <= '0;
            sw_s1_q   <= '0;
            sw_sync_q <= '0;
            err_q     <= 1'b0;
        end else begin
            din_q     <= din_d;
            led_q     <= led_d;
            hex_q     <= hex_d;
            timer_q   <= timer_d;
            presc_q   <= presc_d;
            sw_s1_q   <= sw_s1_d;
            sw_sync_q <= sw_sync_d;
            err_q     <= err_d;
        end
    end

    // RAM array is never cleared; reset only blocks a concurrent write.
    always_ff @(posedge clock) begin
        if (resetn && ram_we) begin
            mem_q[ram_idx] <= bus.DOUT;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder (PRESCALE=4, RAM_AW=7).
// Vector table plus hand-written timer, switch and error sequences.
module tb_mem_io_responder;

    logic        clk;
    logic        resetn;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [15:0] hex_val;
    logic        bus_err;

    mem_io_if bif ();

    mem_io_responder #(
        .RAM_AW   (7),
        .PRESCALE (4),
        .SW_W     (10),
        .LED_W    (10)
    ) dut (
        .clock   (clk),
        .resetn  (resetn),
        .bus     (bif.slave),
        .SW      (sw),
        .LEDR    (ledr),
        .HEX_val (hex_val),
        .bus_err (bus_err)
    );

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [15:0] dout;
        logic        w;
        logic [15:0] exp;
        bit          care;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];
    string       nm_q[$];
    int          total = 0;
    int          bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic [15:0] a,
                        input logic [15:0] d, input logic w,
                        input logic [15:0] e, input bit care);
        logic [15:0] ex;
        string       en;
        @(negedge clk);
        bif.ADDR = a;
        bif.DOUT = d;
        bif.W    = w;
        if (care) begin
            exp_q.push_back(e);
            nm_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        if (care) begin
            if (exp_q.size() == 0) begin
                chk({nm, "_sb_empty"}, 16'd1, 16'd0);
            end else begin
                ex = exp_q.pop_front();
                en = nm_q.pop_front();
                chk(en, bif.DIN, ex);
            end
        end
    endtask

    task automatic reset_dut(input string nm);
        @(negedge clk);
        resetn   = 1'b0;
        bif.W    = 1'b0;
        bif.ADDR = 16'h0000;
        bif.DOUT = 16'h0000;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk({nm, "_din"}, bif.DIN, 16'h0000);
        chk({nm, "_ledr"}, 16'(ledr), 16'h0000);
        chk({nm, "_hex"}, hex_val, 16'h0000);
        chk({nm, "_err"}, 16'(bus_err), 16'h0000);
    endtask

    initial begin
        resetn   = 1'b1;
        sw       = '0;
        bif.ADDR = '0;
        bif.DOUT = '0;
        bif.W    = 1'b0;

        reset_dut("rst0");

        for (int k = 1; k <= 6; k++) begin
            step($sformatf("pre_tmr%0d", k), 16'h3000, 16'h0, 1'b0,
                 16'((k - 1) / 4), 1'b1);
        end
        reset_dut("rst_mid");

        for (int k = 1; k <= 13; k++) begin
            step($sformatf("tmr_run%0d", k), 16'h3000, 16'h0, 1'b0,
                 16'((k - 1) / 4), 1'b1);
        end

        reset_dut("rst_t2");
        step("tmr_wffff", 16'h3000, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            step($sformatf("tmr_hold%0d", k), 16'h3000, 16'h0, 1'b0,
                 16'hFFFF, 1'b1);
        end
        step("tmr_wrap", 16'h3000, 16'h0, 1'b0, 16'h0000, 1'b1);

        reset_dut("rst_t3");
        for (int k = 1; k <= 3; k++) begin
            step($sformatf("tmr_pre%0d", k), 16'h3000, 16'h0, 1'b0,
                 16'h0000, 1'b1);
        end
        step("tmr_wtick", 16'h3000, 16'h0010, 1'b1, 16'h0000, 1'b1);
        for (int k = 5; k <= 8; k++) begin
            step($sformatf("tmr_ld%0d", k), 16'h3000, 16'h0, 1'b0,
                 16'h0010, 1'b1);
        end
        step("tmr_ld_tick", 16'h3000, 16'h0, 1'b0, 16'h0011, 1'b1);

        reset_dut("rst_tbl");
        tbl.push_back('{"ram_w5", 16'h0005, 16'hBEEF, 1'b1, 16'h0, 1'b0});
        tbl.push_back('{"ram_r5", 16'h0005, 16'h0, 1'b0, 16'hBEEF, 1'b1});
        tbl.push_back('{"ram_alias85", 16'h0085, 16'h0, 1'b0, 16'hBEEF, 1'b1});
        tbl.push_back('{"ram_rfirst", 16'h0005, 16'h1234, 1'b1, 16'hBEEF, 1'b1});
        tbl.push_back('{"ram_new", 16'h0005, 16'h0, 1'b0, 16'h1234, 1'b1});
        tbl.push_back('{"ram_aliasF85", 16'h0F85, 16'h0, 1'b0, 16'h1234, 1'b1});
        tbl.push_back('{"led_w", 16'h1000, 16'hFFFF, 1'b1, 16'h0000, 1'b1});
        tbl.push_back('{"led_r", 16'h1000, 16'h0, 1'b0, 16'h03FF, 1'b1});
        tbl.push_back('{"hex_w", 16'h4000, 16'hCAFE, 1'b1, 16'h0000, 1'b1});
        tbl.push_back('{"hex_r", 16'h4000, 16'h0, 1'b0, 16'hCAFE, 1'b1});
        tbl.push_back('{"sw_w", 16'h2000, 16'h5555, 1'b1, 16'h0000, 1'b1});
        tbl.push_back('{"sw_r", 16'h2000, 16'h0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{"ram_w7f", 16'h007F, 16'h0A0A, 1'b1, 16'h0, 1'b0});
        tbl.push_back('{"ram_r7f", 16'h007F, 16'h0, 1'b0, 16'h0A0A, 1'b1});
        tbl.push_back('{"ram_r5b", 16'h0005, 16'h0, 1'b0, 16'h1234, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].name, tbl[i].addr, tbl[i].dout, tbl[i].w,
                 tbl[i].exp, tbl[i].care);
        end
        chk("ledr_val", 16'(ledr), 16'h03FF);
        chk("hex_val", hex_val, 16'hCAFE);
        chk("err_mapped", 16'(bus_err), 16'h0000);

        sw = 10'h2A5;
        step("sw_e1", 16'h2000, 16'h0, 1'b0, 16'h0000, 1'b1);
        step("sw_e2", 16'h2000, 16'h0, 1'b0, 16'h0000, 1'b1);
        step("sw_e3", 16'h2000, 16'h0, 1'b0, 16'h02A5, 1'b1);

        step("unm_w", 16'h9000, 16'h1111, 1'b1, 16'h0000, 1'b1);
        chk("err_set", 16'(bus_err), 16'h0001);
        step("unm_rF", 16'hF000, 16'h0, 1'b0, 16'h0000, 1'b1);
        chk("err_stay1", 16'(bus_err), 16'h0001);
        step("ram_after_err", 16'h0005, 16'h0, 1'b0, 16'h1234, 1'b1);
        chk("err_stay2", 16'(bus_err), 16'h0001);
        chk("ledr_unm", 16'(ledr), 16'h03FF);
        chk("hex_unm", hex_val, 16'hCAFE);

        reset_dut("rst_err");
        step("unm_r5", 16'h5000, 16'h0, 1'b0, 16'h0000, 1'b1);
        chk("err_rd", 16'(bus_err), 16'h0001);
        step("ram_keep", 16'h0005, 16'h0, 1'b0, 16'h1234, 1'b1);

        chk("sb_drained", 16'(exp_q.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
